// File: rtl/ic7475_pkg.sv
// Shared pin-to-bit mapping and reset default for the 7475 latch model.
// Optional Qn outputs on the top are enabled by IC7475_QBAR_EN.
package ic7475_pkg;

  localparam int Q1_BIT = 3;
  localparam int Q2_BIT = 2;
  localparam int Q3_BIT = 1;
  localparam int Q4_BIT = 0;

  localparam logic [3:0] RESET_VAL_DEF = 4'b0000;

  // Extract the reset bits belonging to one latch pair, high bit first.
  function automatic logic [1:0] pair_rst(
    input logic [3:0] rv,
    input int         hi,
    input int         lo
  );
    return {rv[hi], rv[lo]};
  endfunction

endpackage

// File: rtl/ic7475_latch_pair.sv
// Two-bit enable-gated register with async active-low reset.
// Emulates one transparent latch pair on a single clock.
module ic7475_latch_pair
  import ic7475_pkg::*;
#(
  parameter logic [1:0] RST = 2'b00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] d,
  output logic [1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ic7475_latch.sv
// 7475 4-bit bistable latch, DIP pin names, clocked flip-flop emulation.
// Define IC7475_QBAR_EN to add inverted outputs p1,p14,p11,p8.
module ic7475_latch
  import ic7475_pkg::*;
#(
  parameter logic [3:0] RESET_VAL = RESET_VAL_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic p2,
  input  logic p3,
  input  logic p6,
  input  logic p7,
  input  logic p13,
  input  logic p4,
`ifdef IC7475_QBAR_EN
  output logic p1,
  output logic p14,
  output logic p11,
  output logic p8,
`endif
  output logic p16,
  output logic p15,
  output logic p10,
  output logic p9
);

  localparam logic [1:0] RST12 =
    pair_rst(RESET_VAL, Q1_BIT, Q2_BIT);
  localparam logic [1:0] RST34 =
    pair_rst(RESET_VAL, Q3_BIT, Q4_BIT);

  logic [1:0] q12;
  logic [1:0] q34;
  logic [3:0] q;

  ic7475_latch_pair #(
    .RST (RST12)
  ) u_pair12 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (p13),
    .d     ({p2, p3}),
    .q     (q12)
  );

  ic7475_latch_pair #(
    .RST (RST34)
  ) u_pair34 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (p4),
    .d     ({p6, p7}),
    .q     (q34)
  );

  assign q[Q1_BIT] = q12[1];
  assign q[Q2_BIT] = q12[0];
  assign q[Q3_BIT] = q34[1];
  assign q[Q4_BIT] = q34[0];

  assign p16 = q[Q1_BIT];
  assign p15 = q[Q2_BIT];
  assign p10 = q[Q3_BIT];
  assign p9  = q[Q4_BIT];

`ifdef IC7475_QBAR_EN
  // Qn follows the registered Q, so it also reads ~RESET_VAL in reset.
  assign p1  = ~q[Q1_BIT];
  assign p14 = ~q[Q2_BIT];
  assign p11 = ~q[Q3_BIT];
  assign p8  = ~q[Q4_BIT];
`endif

endmodule

// File: tb/tb_ic7475_latch.sv
// Self-checking bench for ic7475_latch: vector table, corner sequences,
// and randomized run against a bit-level reference model.
module tb_ic7475_latch;

  logic clk;
  logic rst_n;
  logic p2, p3, p6, p7, p13, p4;
  logic p16, p15, p10, p9;
`ifdef IC7475_QBAR_EN
  logic p1, p14, p11, p8;
`endif

  int total = 0;
  int bad   = 0;

  ic7475_latch dut (
    .clk   (clk),
    .rst_n (rst_n),
    .p2    (p2),
    .p3    (p3),
    .p6    (p6),
    .p7    (p7),
    .p13   (p13),
    .p4    (p4),
`ifdef IC7475_QBAR_EN
    .p1    (p1),
    .p14   (p14),
    .p11   (p11),
    .p8    (p8),
`endif
    .p16   (p16),
    .p15   (p15),
    .p10   (p10),
    .p9    (p9)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] d;
    logic       e12;
    logic       e34;
    logic [3:0] exp;
    string      name;
  } vec_t;

  function automatic logic [3:0] qv();
    return {p16, p15, p10, p9};
  endfunction

  task automatic chk(input string name, input logic [3:0] exp);
    logic [3:0] act;
    act = qv();
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: q=%b expected=%b", name, act, exp);
    end
`ifdef IC7475_QBAR_EN
    total++;
    if ({p1, p14, p11, p8} !== ~exp) begin
      bad++;
      $display("FAIL %s_qn: qn=%b expected=%b",
               name, {p1, p14, p11, p8}, ~exp);
    end
`endif
  endtask

  task automatic drive(input logic [3:0] d, input logic e12,
                       input logic e34);
    {p2, p3, p6, p7} = d;
    p13 = e12;
    p4  = e34;
  endtask

  vec_t vecs[$];
  logic [3:0] m;

  initial begin
    rst_n = 1'b1;
    drive(4'b1111, 1'b1, 1'b1);
    @(negedge clk);

    // Reset asserted with enables/data active: immediate clear, holds.
    rst_n = 1'b0;
    #1;
    chk("reset_immediate", 4'b0000);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hold3", 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;

    vecs.push_back('{4'b1011, 1'b1, 1'b0, 4'b1000, "pair1_capture"});
    vecs.push_back('{4'b0010, 1'b0, 1'b1, 4'b1010, "pair2_capture"});
    vecs.push_back('{4'b1111, 1'b0, 1'b0, 4'b1010, "hold_1111"});
    vecs.push_back('{4'b0000, 1'b0, 1'b0, 4'b1010, "hold_0000"});
    vecs.push_back('{4'b1111, 1'b0, 1'b0, 4'b1010, "hold_1111b"});
    vecs.push_back('{4'b0000, 1'b0, 1'b0, 4'b1010, "hold_0000b"});
    vecs.push_back('{4'bxxxx, 1'b0, 1'b0, 4'b1010, "hold_x_data"});
    vecs.push_back('{4'b0100, 1'b1, 1'b1, 4'b0100, "follow_0100"});
    vecs.push_back('{4'b1010, 1'b1, 1'b1, 4'b1010, "follow_1010"});

    foreach (vecs[i]) begin
      drive(vecs[i].d, vecs[i].e12, vecs[i].e34);
      // Before the edge nothing may have changed yet.
      #1;
      if (i == 7) chk("no_comb_path", 4'b1010);
      @(posedge clk);
      #1;
      chk(vecs[i].name, vecs[i].exp);
      @(negedge clk);
    end

    // Reset between edges with Q=1010 clears before the next edge.
    drive(4'b1111, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_midrun", 4'b0000);
    @(posedge clk);
    #1;
    chk("reset_over_enable", 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("first_after_reset", 4'b1111);

    // Randomized run against a per-bit model.
    m = 4'b1111;
    for (int c = 0; c < 400; c++) begin
      logic [3:0] d;
      logic e12, e34;
      @(negedge clk);
      d   = 4'($urandom);
      e12 = 1'($urandom);
      e34 = 1'($urandom);
      drive(d, e12, e34);
      rst_n = ($urandom_range(0, 19) != 0);
      #1;
      if (!rst_n) begin
        m = 4'b0000;
        chk("rand_async_reset", m);
      end
      @(posedge clk);
      if (rst_n) begin
        for (int b = 0; b < 4; b++) begin
          // bits 3,2 are Q1,Q2 (enable p13); bits 1,0 are Q3,Q4 (p4)
          if ((b >= 2) ? e12 : e34) m[b] = d[b];
        end
      end
      #1;
      chk("rand_cycle", m);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
